// File: rtl/muldiv_seq.sv
// Sequential multiply/divide unit with HI/LO result registers.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes, one step per cycle.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_is_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_div0;
  logic             r_done;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_neg_a;
  logic             w_neg_b;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_res_hi;
  logic [WIDTH-1:0] w_res_lo;

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    w_neg_a = op[0] & a[WIDTH-1];
    w_neg_b = op[0] & b[WIDTH-1];
    w_mag_a = w_neg_a ? -a : a;
    w_mag_b = w_neg_b ? -b : b;

    // Multiply: r_acc:r_q is the partial product, r_q shifts out multiplier bits.
    w_sum   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_opb} : '0);
    // Divide: r_acc is the partial remainder, r_q shifts dividend out and quotient in.
    w_shift = {r_acc, r_q[WIDTH-1]};
    w_diff  = w_shift[WIDTH-1:0] - r_opb;
    w_ge    = (w_shift >= {1'b0, r_opb});

    if (r_is_div) begin
      w_acc_nxt = w_ge ? w_diff : w_shift[WIDTH-1:0];
      w_q_nxt   = {r_q[WIDTH-2:0], w_ge};
    end else begin
      w_acc_nxt = w_sum[WIDTH:1];
      w_q_nxt   = {w_sum[0], r_q[WIDTH-1:1]};
    end

    w_prod   = r_neg_q ? -{r_acc, r_q} : {r_acc, r_q};
    w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
    if (r_is_div) begin
      // With a zero divisor the remainder ends up as |a|; re-signing it restores a.
      w_res_hi = r_neg_r ? -r_acc : r_acc;
      w_res_lo = r_div0 ? '1 : (r_neg_q ? -r_q : r_q);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, and every register,
  // datapath included, is cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_done   <= 1'b0;
      r_opb    <= '0;
      r_acc    <= '0;
      r_q      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            case (op)
              3'b000, 3'b001, 3'b010, 3'b011: begin
                r_state  <= RUN;
                r_cnt    <= '0;
                r_is_div <= op[1];
                r_neg_q  <= w_neg_a ^ w_neg_b;
                r_neg_r  <= w_neg_a;
                r_div0   <= op[1] && (b == '0);
                r_opb    <= w_mag_b;
                r_acc    <= '0;
                r_q      <= w_mag_a;
              end
              3'b100:  r_hi <= a;
              3'b101:  r_lo <= a;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (cancel) begin
            r_state <= IDLE;
          end else begin
            r_acc <= w_acc_nxt;
            r_q   <= w_q_nxt;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == LAST) r_state <= FIX;
          end
        end
        FIX: begin
          r_state <= IDLE;
          if (!cancel) begin
            r_hi   <= w_res_hi;
            r_lo   <= w_res_lo;
            r_done <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = (r_state != IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
